taint_sum_scanner: RTL

//  Periodic scheduler that sequences readout of taint_sum outputs from N taint-tracking cells (dff/mem).

---
 rtl/taint_scan_pkg.sv | 24 ++
 rtl/taint_sum_scanner_if.sv | 43 ++++
 rtl/taint_scan_timer.sv | 57 +++++
 rtl/taint_sum_scanner.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/taint_scan_pkg.sv
// rtl/taint_scan_pkg.sv - shared types, constants and helpers for the taint-sum scanner
//
// Purpose : scan FSM state encoding, overrun counter width and the index-width
//           helper used by the scanner top and its log interface.
// Ports   : none (package).

package taint_scan_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SNAP = 3'd1,
    SCAN = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4
  } scan_state_t;

  localparam int OVERRUN_W = 8;

  // Width of a source index; at least one bit even for tiny source counts.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/taint_sum_scanner_if.sv
// rtl/taint_sum_scanner_if.sv - valid/ready log record port of the taint-sum scanner
//
// Purpose : one record per reportable source, held until the logger accepts it.
// Signals : out_valid  record valid            (master -> slave)
//           out_ready  logger accepts record   (slave -> master)
//           out_src    source index            (master -> slave)
//           out_sum    snapshot sum of source  (master -> slave)
//           out_epoch  scan epoch of record    (master -> slave)
// Modports: master = scanner side, slave = logger side.

interface taint_sum_scanner_if
  import taint_scan_pkg::*;
#(
  parameter int N_SRC   = 8,
  parameter int SUM_W   = 8,
  parameter int EPOCH_W = 16
) ();

  localparam int IDX_W = idx_w(N_SRC);

  logic               out_valid;
  logic               out_ready;
  logic [IDX_W-1:0]   out_src;
  logic [SUM_W-1:0]   out_sum;
  logic [EPOCH_W-1:0] out_epoch;

  modport master (
    output out_valid,
    output out_src,
    output out_sum,
    output out_epoch,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_src,
    input  out_sum,
    input  out_epoch,
    output out_ready
  );

endinterface

// File: rtl/taint_scan_timer.sv
// rtl/taint_scan_timer.sv - period counter producing the scan tick
//
// Purpose : raises a one-cycle registered tick every `period` cycles while
//           enable is high; the first tick appears exactly `period` cycles
//           after enable rises. period == 0 ticks every enabled cycle.
// Ports   : pos_clk   in   clock, rising edge
//           pos_arst  in   reset, asynchronous, active-high
//           enable    in   run the counter; low holds it at period-1
//           period    in   tick interval in cycles
//           tick      out  registered tick pulse

module taint_scan_timer #(
  parameter int PERIOD_W = 16
) (
  input  logic                pos_clk,
  input  logic                pos_arst,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] reload;
  logic [PERIOD_W-1:0] cur;
  logic                en_q;

  assign reload = period - ONE;
  // On the first enabled cycle the stored count may be stale (reset, or a
  // period change while disabled), so the live reload value is used instead.
  assign cur    = en_q ? cnt : reload;

  always_ff @(posedge pos_clk or posedge pos_arst) begin
    if (pos_arst) begin
      cnt  <= '0;
      en_q <= 1'b0;
      tick <= 1'b0;
    end else begin
      en_q <= enable;
      if (!enable) begin
        cnt  <= reload;
        tick <= 1'b0;
      end else if (period == '0) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else if (cur == '0) begin
        cnt  <= reload;
        tick <= 1'b1;
      end else begin
        cnt  <= cur - ONE;
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/taint_sum_scanner.sv
// rtl/taint_sum_scanner.sv - periodic snapshot-and-scan readout of taint_sum cells
//
// Purpose : every period cycles snapshot all source sums, then walk the sources
//           one by one and emit a log record for each reportable source.
//           Observes only; never drives tracked logic.
// Build   : TAINT_SCAN_DELTA_EN defined -> a source is reportable when its
//           snapshot differs from the previous completed scan (drops to zero
//           included); undefined -> reportable when nonzero.
// Ports   : pos_clk    in   clock, rising edge
//           pos_arst   in   reset, asynchronous, active-high
//           enable     in   allow new scans
//           period     in   scan interval in cycles; 0 = back-to-back
//           src_sum    in   source i at [i*SUM_W +: SUM_W]
//           log        if   master side of the record port
//           scan_busy  out  scan in progress
//           scan_done  out  one-cycle pulse at end of scan
//           total_sum  out  sum of all snapshot values of the last completed scan
//           overrun    out  saturating count of ticks lost while busy

module taint_sum_scanner
  import taint_scan_pkg::*;
#(
  parameter int N_SRC    = 8,
  parameter int SUM_W    = 8,
  parameter int PERIOD_W = 16,
  parameter int EPOCH_W  = 16
) (
  input  logic                        pos_clk,
  input  logic                        pos_arst,
  input  logic                        enable,
  input  logic [PERIOD_W-1:0]         period,
  input  logic [N_SRC*SUM_W-1:0]      src_sum,
  taint_sum_scanner_if.master         log,
  output logic                        scan_busy,
  output logic                        scan_done,
  output logic [SUM_W+idx_w(N_SRC):0] total_sum,
  output logic [OVERRUN_W-1:0]        overrun
);

  localparam int IDX_W = idx_w(N_SRC);
  localparam int ACC_W = SUM_W + IDX_W + 1;

  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(N_SRC - 1);
  localparam logic [IDX_W-1:0]     IDX_ONE   = IDX_W'(1);
  localparam logic [EPOCH_W-1:0]   EPOCH_ONE = EPOCH_W'(1);
  localparam logic [OVERRUN_W-1:0] OVR_ONE   = OVERRUN_W'(1);

  logic tick;

  taint_scan_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .pos_clk  (pos_clk),
    .pos_arst (pos_arst),
    .enable   (enable),
    .period   (period),
    .tick     (tick)
  );

  scan_state_t        state;
  logic [IDX_W-1:0]   idx;
  logic [ACC_W-1:0]   acc;
  logic [EPOCH_W-1:0] epoch;

  logic               valid_q;
  logic [IDX_W-1:0]   src_q;
  logic [SUM_W-1:0]   sum_q;
  logic [EPOCH_W-1:0] rec_epoch_q;

  logic [SUM_W-1:0]   snap  [N_SRC];
  logic [SUM_W-1:0]   clean [N_SRC];
`ifdef TAINT_SCAN_DELTA_EN
  logic [SUM_W-1:0]   prev  [N_SRC];
`endif

  logic req;
  logic back_to_back;
  logic reportable;
  logic last_src;

  // The timer's tick is one cycle old; qualifying it with the live enable
  // keeps a scan request or overrun count from outliving enable.
  assign req          = tick & enable;
  assign back_to_back = (period == '0);
  assign last_src     = (idx == LAST_IDX);

  // Unknown bits from uninstrumented cells read as 0, matching the cells' own
  // convention for untainted state.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      for (int b = 0; b < SUM_W; b++) begin
        clean[i][b] = (src_sum[i*SUM_W + b] === 1'b1);
      end
    end
  end

  always_comb begin
`ifdef TAINT_SCAN_DELTA_EN
    reportable = (snap[idx] != prev[idx]);
`else
    reportable = (snap[idx] != '0);
`endif
  end

  assign log.out_valid = valid_q;
  assign log.out_src   = src_q;
  assign log.out_sum   = sum_q;
  assign log.out_epoch = rec_epoch_q;
  assign scan_busy     = (state != IDLE);

  always_ff @(posedge pos_clk or posedge pos_arst) begin
    if (pos_arst) begin
      state       <= IDLE;
      idx         <= '0;
      acc         <= '0;
      epoch       <= '0;
      valid_q     <= 1'b0;
      src_q       <= '0;
      sum_q       <= '0;
      rec_epoch_q <= '0;
      scan_done   <= 1'b0;
      total_sum   <= '0;
      overrun     <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        snap[i] <= '0;
`ifdef TAINT_SCAN_DELTA_EN
        prev[i] <= '0;
`endif
      end
    end else begin
      scan_done <= 1'b0;

      // In back-to-back mode a request is present every cycle by design, so
      // nothing is lost while busy and the counter stays put.
      if (req && (state != IDLE) && !back_to_back && (overrun != '1)) begin
        overrun <= overrun + OVR_ONE;
      end

      case (state)
        IDLE: begin
          if (req) begin
            state <= SNAP;
          end
        end

        SNAP: begin
          for (int i = 0; i < N_SRC; i++) begin
            snap[i] <= clean[i];
          end
          idx   <= '0;
          acc   <= '0;
          state <= SCAN;
        end

        SCAN: begin
          acc <= acc + ACC_W'(snap[idx]);
          if (reportable) begin
            valid_q     <= 1'b1;
            src_q       <= idx;
            sum_q       <= snap[idx];
            rec_epoch_q <= epoch;
            state       <= EMIT;
          end else if (last_src) begin
            scan_done <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IDX_ONE;
          end
        end

        EMIT: begin
          if (log.out_ready) begin
            valid_q <= 1'b0;
            if (last_src) begin
              scan_done <= 1'b1;
              state     <= DONE;
            end else begin
              idx   <= idx + IDX_ONE;
              state <= SCAN;
            end
          end
        end

        DONE: begin
          total_sum <= acc;
          epoch     <= epoch + EPOCH_ONE;
`ifdef TAINT_SCAN_DELTA_EN
          for (int i = 0; i < N_SRC; i++) begin
            prev[i] <= snap[i];
          end
`endif
          // Back-to-back scans chain straight into the next snapshot.
          state <= (enable && back_to_back) ? SNAP : IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
